// File: rtl/operand_fetch_if.sv
// operand_fetch_if: decode, register memory, write-back and execute signals of the issue stage
interface operand_fetch_if #(
  parameter int WIDTH = 32,
  parameter int N = 4
);
  localparam int AW = $clog2(N);
  logic in_valid;
  logic in_ready;
  logic [AW-1:0] in_rs1;
  logic [AW-1:0] in_rs2;
  logic [AW-1:0] in_rd;
  logic in_rd_we;
  logic [1:0] rf_read_en;
  logic [AW-1:0] rf_read_adr [2];
  logic [WIDTH-1:0] rf_data [2];
  logic wb_en;
  logic [AW-1:0] wb_adr;
  logic [WIDTH-1:0] wb_data;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_op1;
  logic [WIDTH-1:0] out_op2;
  logic [AW-1:0] out_rd;
  logic out_rd_we;
  modport master (
    input in_valid, in_rs1, in_rs2, in_rd, in_rd_we, rf_data, wb_en, wb_adr, wb_data, out_ready,
    output in_ready, rf_read_en, rf_read_adr, out_valid, out_op1, out_op2, out_rd, out_rd_we
  );
  modport slave (
    output in_valid, in_rs1, in_rs2, in_rd, in_rd_we, rf_data, wb_en, wb_adr, wb_data, out_ready,
    input in_ready, rf_read_en, rf_read_adr, out_valid, out_op1, out_op2, out_rd, out_rd_we
  );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: issue stage with busy scoreboard, write-back bypass and valid/ready output
module operand_fetch #(
  parameter int WIDTH = 32,
  parameter int N = 4
) (
  input logic clk,
  input logic reset,
  operand_fetch_if.master f
);
  localparam int AW = $clog2(N);
  typedef enum logic [1:0] {IDLE, CHECK, READ, VALID} state_t;
  state_t state, next;
  logic [AW-1:0] rs1, rs2, rd;
  logic rd_we;
  logic [N-1:0] busy, set_mask, clr_mask;
  logic [1:0] bypass;
  logic [WIDTH-1:0] wb_cap;
  logic hit1, hit2, hitd, stall, hs;
  // hazard detection; a write-back landing this cycle resolves the hazard on its register
  always_comb begin
    hit1 = f.wb_en && f.wb_adr == rs1;
    hit2 = f.wb_en && f.wb_adr == rs2;
    hitd = f.wb_en && f.wb_adr == rd;
    stall = (busy[rs1] && !hit1) || (busy[rs2] && !hit2) || (rd_we && busy[rd] && !hitd);
    hs = state == VALID && f.out_ready;
    set_mask = (hs && f.out_rd_we) ? N'(1) << f.out_rd : '0;
    clr_mask = f.wb_en ? N'(1) << f.wb_adr : '0;
  end
  // state register
  always_ff @(posedge clk)
    state <= !reset ? IDLE : next;
  // next-state logic
  always_comb begin
    next = state;
    case (state)
      IDLE: next = (f.in_valid && f.in_ready) ? CHECK : IDLE;
      CHECK: next = stall ? CHECK : READ;
      READ: next = VALID;
      VALID: next = !f.out_ready ? VALID : f.in_valid ? CHECK : IDLE;
      default: next = IDLE;
    endcase
  end
  // handshake and register-memory read outputs
  always_comb begin
    f.in_ready = state == IDLE || hs;
    f.out_valid = state == VALID;
    f.rf_read_en = (state == CHECK && !stall) ? 2'b11 : 2'b00;
    f.rf_read_adr[0] = rs1;
    f.rf_read_adr[1] = rs2;
  end
  // instruction latch, bypass capture, operand registers and scoreboard; set beats clear on one register
  always_ff @(posedge clk) begin
    if (!reset) begin
      {rs1, rs2, rd, rd_we} <= '0;
      bypass <= '0;
      wb_cap <= '0;
      busy <= '0;
      f.out_op1 <= '0;
      f.out_op2 <= '0;
      f.out_rd <= '0;
      f.out_rd_we <= 1'b0;
    end else begin
      if (f.in_valid && f.in_ready)
        {rs1, rs2, rd, rd_we} <= {f.in_rs1, f.in_rs2, f.in_rd, f.in_rd_we};
      if (state == CHECK && !stall) begin
        bypass <= {hit2, hit1};
        wb_cap <= f.wb_data;
      end
      if (state == READ) begin
        f.out_op1 <= bypass[0] ? wb_cap : f.rf_data[0];
        f.out_op2 <= bypass[1] ? wb_cap : f.rf_data[1];
        f.out_rd <= rd;
        f.out_rd_we <= rd_we;
        bypass <= '0;
      end
      busy <= (busy & ~clr_mask) | set_mask;
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed checks of operand_fetch against an architectural register/scoreboard model
module tb_operand_fetch;
  localparam int W = 32;
  localparam int N = 4;
  typedef struct packed {logic [1:0] rs1, rs2, rd; logic we;} ins_t;
  logic clk = 0;
  logic reset = 0;
  always #5 clk = ~clk;
  operand_fetch_if #(.WIDTH(W), .N(N)) f();
  operand_fetch #(.WIDTH(W), .N(N)) dut(.clk(clk), .reset(reset), .f(f));
  // register memory: registered reads return the old value on a same-edge write
  logic [W-1:0] mem [N];
  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) if (f.rf_read_en[p]) f.rf_data[p] <= mem[f.rf_read_adr[p]];
    if (f.wb_en) mem[f.wb_adr] <= f.wb_data;
  end
  int n_checks = 0;
  int n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // model: in-flight instructions, architectural register values, registers awaiting a write
  ins_t q[$];
  logic [W-1:0] arch [N];
  logic [N-1:0] mbusy = '0;
  logic pv = 0, pr = 0;
  logic [W-1:0] p1, p2;
  logic [1:0] prd;
  always @(negedge clk) begin : cmp
    ins_t h;
    logic hs;
    if (!reset) begin
      q.delete();
      mbusy = '0;
      pv = 0;
    end else begin
      chk("busy", dut.busy, mbusy);
      if (pv && !pr) begin
        chk("hold valid", f.out_valid, 1);
        chk("hold op1", f.out_op1, p1);
        chk("hold op2", f.out_op2, p2);
        chk("hold rd", f.out_rd, prd);
      end
      if (f.out_valid) begin
        if (q.size() == 0) chk("out_valid with nothing issued", f.out_valid, 0);
        else begin
          chk("model op1", f.out_op1, arch[q[0].rs1]);
          chk("model op2", f.out_op2, arch[q[0].rs2]);
          chk("model rd", f.out_rd, q[0].rd);
          chk("model rd_we", f.out_rd_we, q[0].we);
        end
      end
      hs = f.out_valid && f.out_ready && q.size() > 0;
      h = hs ? q.pop_front() : '0;
      if (f.wb_en) begin
        mbusy[f.wb_adr] = 1'b0;
        arch[f.wb_adr] = f.wb_data;
      end
      if (hs && h.we) mbusy[h.rd] = 1'b1;
      if (f.in_valid && f.in_ready) q.push_back({f.in_rs1, f.in_rs2, f.in_rd, f.in_rd_we});
      pv = f.out_valid;
      pr = f.out_ready;
      p1 = f.out_op1;
      p2 = f.out_op2;
      prd = f.out_rd;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [1:0] a, input logic [1:0] b, input logic [1:0] d, input logic we);
    f.in_rs1 = a;
    f.in_rs2 = b;
    f.in_rd = d;
    f.in_rd_we = we;
    f.in_valid = 1;
    #1;
    for (int i = 0; i < 20 && !f.in_ready; i++) tick();
    chk("in_ready before accept", f.in_ready, 1);
    tick();
    f.in_valid = 0;
  endtask
  task automatic wb(input logic [1:0] a, input logic [W-1:0] d);
    f.wb_en = 1;
    f.wb_adr = a;
    f.wb_data = d;
    tick();
    f.wb_en = 0;
  endtask
  task automatic wb_now(input logic [1:0] a, input logic [W-1:0] d);
    f.wb_en = 1;
    f.wb_adr = a;
    f.wb_data = d;
    #1;
    chk("read on check exit", f.rf_read_en, 2'b11);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    f.in_valid = 0;
    f.in_rs1 = 0;
    f.in_rs2 = 0;
    f.in_rd = 0;
    f.in_rd_we = 0;
    f.out_ready = 0;
    f.wb_en = 0;
    f.wb_adr = 0;
    f.wb_data = 0;
    repeat (3) tick();
    chk("reset out_valid", f.out_valid, 0);
    chk("reset in_ready", f.in_ready, 1);
    chk("reset rf_read_en", f.rf_read_en, 0);
    chk("reset busy", dut.busy, 0);
    chk("reset op1", f.out_op1, 0);
    chk("reset op2", f.out_op2, 0);
    chk("reset rd", f.out_rd, 0);
    chk("reset rd_we", f.out_rd_we, 0);
    reset = 1;
    wb(1, 'h11);
    wb(2, 'h22);
    wb(0, 'h5);
    wb(3, 'h33);
    // basic issue, 3-cycle latency
    issue(1, 2, 3, 1);
    chk("t1 read en", f.rf_read_en, 2'b11);
    chk("t1 adr0", f.rf_read_adr[0], 1);
    chk("t1 adr1", f.rf_read_adr[1], 2);
    chk("t1 not yet valid", f.out_valid, 0);
    tick();
    chk("t1 read cycle", f.out_valid, 0);
    tick();
    chk("t1 valid", f.out_valid, 1);
    chk("t1 op1", f.out_op1, 'h11);
    chk("t1 op2", f.out_op2, 'h22);
    chk("t1 rd", f.out_rd, 3);
    f.out_ready = 1;
    tick();
    f.out_ready = 0;
    chk("t1 busy", dut.busy, 4'b1000);
    chk("t1 idle ready", f.in_ready, 1);
    // RAW stall resolved by write-back bypass
    issue(3, 0, 0, 0);
    repeat (5) begin
      chk("raw stall", f.rf_read_en, 0);
      tick();
    end
    wb_now(3, 'hABCD);
    tick();
    f.wb_en = 0;
    chk("raw busy cleared", dut.busy, 0);
    tick();
    chk("raw valid", f.out_valid, 1);
    chk("raw op1 bypass", f.out_op1, 'hABCD);
    chk("raw op2", f.out_op2, 'h5);
    // back-pressure, then accept during handshake
    repeat (4) begin
      tick();
      chk("bp valid", f.out_valid, 1);
      chk("bp in_ready", f.in_ready, 0);
      chk("bp op1", f.out_op1, 'hABCD);
    end
    f.in_rs1 = 1;
    f.in_rs2 = 2;
    f.in_rd = 2;
    f.in_rd_we = 1;
    f.in_valid = 1;
    f.out_ready = 1;
    #1;
    chk("bp accept ready", f.in_ready, 1);
    tick();
    f.in_valid = 0;
    f.out_ready = 0;
    chk("bp next check", f.out_valid, 0);
    chk("bp next read en", f.rf_read_en, 2'b11);
    tick();
    tick();
    chk("bp next op1", f.out_op1, 'h11);
    chk("bp next op2", f.out_op2, 'h22);
    chk("bp next rd", f.out_rd, 2);
    // set and clear of the same register in one cycle
    f.out_ready = 1;
    tick();
    f.out_ready = 0;
    chk("sc busy2", dut.busy, 4'b0100);
    issue(0, 0, 2, 1);
    repeat (3) begin
      chk("waw2 stall", f.rf_read_en, 0);
      tick();
    end
    wb_now(2, 'h77);
    tick();
    f.wb_en = 0;
    chk("waw2 cleared", dut.busy, 0);
    tick();
    chk("waw2 op1", f.out_op1, 'h5);
    f.out_ready = 1;
    f.wb_en = 1;
    f.wb_adr = 2;
    f.wb_data = 'h78;
    tick();
    f.out_ready = 0;
    f.wb_en = 0;
    chk("set wins", dut.busy, 4'b0100);
    // WAW on r1
    issue(0, 0, 1, 1);
    tick();
    tick();
    f.out_ready = 1;
    tick();
    f.out_ready = 0;
    chk("waw1 busy", dut.busy, 4'b0110);
    issue(0, 0, 1, 1);
    repeat (3) begin
      chk("waw1 stall", f.rf_read_en, 0);
      tick();
    end
    wb_now(1, 'h99);
    tick();
    f.wb_en = 0;
    chk("waw1 after wb", dut.busy, 4'b0100);
    tick();
    chk("waw1 valid", f.out_valid, 1);
    chk("waw1 op2", f.out_op2, 'h5);
    // reset in READ
    f.in_rs1 = 0;
    f.in_rs2 = 0;
    f.in_rd = 3;
    f.in_rd_we = 0;
    f.in_valid = 1;
    f.out_ready = 1;
    tick();
    f.in_valid = 0;
    f.out_ready = 0;
    chk("pre-reset busy", dut.busy, 4'b0110);
    tick();
    chk("in read", f.out_valid, 0);
    reset = 0;
    tick();
    chk("mid reset valid", f.out_valid, 0);
    chk("mid reset in_ready", f.in_ready, 1);
    chk("mid reset busy", dut.busy, 0);
    chk("mid reset read en", f.rf_read_en, 0);
    reset = 1;
    tick();
    chk("post reset idle", f.out_valid, 0);
    // rs1 == rs2, both ports bypass
    issue(2, 2, 0, 1);
    wb_now(2, 'hBEEF);
    tick();
    f.wb_en = 0;
    tick();
    chk("dup op1", f.out_op1, 'hBEEF);
    chk("dup op2", f.out_op2, 'hBEEF);
    f.out_ready = 1;
    tick();
    f.out_ready = 0;
    chk("dup busy", dut.busy, 4'b0001);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Issue stage between instruction decode and execute.
- Accepts one decoded instruction at a time (source registers rs1/rs2, destination rd).
- Reads both operands from the multiport register memory through its two registered read ports.
- Stalls on pending writes using a per-register busy scoreboard, bypasses a same-cycle write-back, and presents operands to execute over a valid/ready handshake.

Parameters:
- WIDTH, 32, operand/data width; must match the register memory WIDTH.
- N, 4, number of registers; address width is $clog2(N).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  decoded instruction available.
- in_ready  output  1  stage accepts an instruction this cycle.
- in_rs1  input  $clog2(N)  source register 1.
- in_rs2  input  $clog2(N)  source register 2.
- in_rd  input  $clog2(N)  destination register.
- in_rd_we  input  1  instruction writes rd.
- rf_read_en  output  2  read enables to register memory ports 0/1.
- rf_read_adr  output  $clog2(N) x2 (unpacked)  read addresses, port 0 = rs1, port 1 = rs2.
- rf_data  input  WIDTH x2 (unpacked)  register memory data_out; valid the cycle after rf_read_en.
- wb_en  input  1  write-back strobe (same signal driving register memory write_en[0]).
- wb_adr  input  $clog2(N)  write-back address.
- wb_data  input  WIDTH  write-back data.
- out_valid  output  1  operands valid to execute.
- out_ready  input  1  execute accepts.
- out_op1  output  WIDTH  rs1 value.
- out_op2  output  WIDTH  rs2 value.
- out_rd  output  $clog2(N)  destination register.
- out_rd_we  output  1  destination write enable.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, busy[N-1:0]=0.
  - out_valid=0; out_op1, out_op2, out_rd, out_rd_we all 0.
  - rf_read_en=0, bypass flags cleared.
  - Reset mid-operation discards the held instruction with no scoreboard update.
- FSM states: IDLE, CHECK, READ, VALID.
- in_ready = (state==IDLE) || (state==VALID && out_ready). An accept latches rs1, rs2, rd, rd_we and moves to CHECK.
- CHECK: the instruction stalls while any of these hold:
  - hz1 = busy[rs1] && !(wb_en && wb_adr==rs1)
  - hz2 = busy[rs2] && !(wb_en && wb_adr==rs2)
  - waw = rd_we && busy[rd] && !(wb_en && wb_adr==rd)
- CHECK exit, when none hold:
  - rf_read_en=2'b11 with rf_read_adr={rs1,rs2}, combinational in this cycle only; transition to READ.
  - For each source with wb_en && wb_adr==rsX: set bypassX=1 and capture wb_data. The memory returns the old value when a read and a write to the same address happen on the same edge.
- READ: out_opX <= bypassX ? captured wb_data : rf_data[X]; clear bypass flags; transition to VALID.
- VALID: out_valid=1. out_op*, out_rd and out_rd_we stay stable until the handshake.
  - out_valid && out_ready with in_valid → accept the next instruction, go to CHECK.
  - out_valid && out_ready without in_valid → go to IDLE.
- Minimum latency is 3 cycles, accept to out_valid. Back-to-back throughput is 1 per 3 cycles.
- Scoreboard:
  - Set: busy[out_rd] <= 1 on the out handshake when out_rd_we==1.
  - Clear: busy[wb_adr] <= 0 when wb_en==1.
  - Same register set and cleared in one cycle: set wins (the newer writer owns it).
  - Different registers: both updates apply.
- Hazard check uses busy as registered, so a register issued in cycle t is busy for the CHECK in cycle t+1.
- wb_en is honoured in every state, including IDLE and while stalled.
- rs1==rs2 is legal: both ports read the same address and each bypasses independently.
- No register is hardwired to zero.

Test Plan:
- Reset, then accept {rs1=1, rs2=2, rd=3, rd_we=1}. Register memory holds r1=0x11, r2=0x22 → out_valid 3 cycles after accept with op1=0x11, op2=0x22. After the handshake busy=4'b1000.
- RAW stall: issue rd=3 as above, then accept {rs1=3, rs2=0}; hold wb_en low 5 cycles → stays in CHECK, rf_read_en=0. Then wb_en=1, wb_adr=3, wb_data=0xABCD → exits CHECK that cycle, out_op1=0xABCD (bypass), busy[3]=0 next cycle.
- Back-pressure: out_ready=0 for 4 cycles in VALID → out_valid, out_op1, out_op2 and out_rd stay constant, in_ready=0. Then out_ready=1 with in_valid=1 → next instruction accepted the same cycle.
- Simultaneous set/clear: busy[2]=1, and the out handshake with rd=2, rd_we=1 coincides with wb_en to address 2 → busy[2] remains 1.
- WAW: busy[1]=1, accept {rd=1, rd_we=1, rs1=0, rs2=0} → stalls until wb_en to address 1, then proceeds.
- Reset mid-READ with busy=4'b0110 → next cycle state IDLE, busy=0, out_valid=0, in_ready=1.
